icache_refill_ctrl: RTL and testbench

- Memory-subsystem responder for the instruction cache miss/refill interface.
- Accepts line-miss requests from the icache into a small request FIFO and issues one line read per request to the memory port.
- Assembles the 8 returned 64-bit beats into a 512-bit line and delivers it to the icache over the refill handshake.
- Requests are serviced strictly one at a time, in order.

---
 rtl/icache_refill_ctrl.sv | 153 +++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Icache miss responder: queues line misses, issues one memory line read per miss, assembles beats into a refill line.
// Latency push->refill valid = 3 + BEAT_NUM cycles at zero wait; misses stall on a full FIFO, the refill holds until accepted.

module fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Full-ness alone gates the push: a same-cycle pop does not free a slot early.
    assign push_rdy = (count != (PTR_W+1)'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_dat;
    end
endmodule

module icache_refill_ctrl #(
    parameter int REQ_DEPTH    = 2,
    parameter int LINE_SIZE    = 512,
    parameter int BEAT_WIDTH   = 64,
    parameter int BEAT_NUM     = 8,
    parameter int OFFSET_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_miss_valid_i,
    output logic                  icache_miss_ready_o,
    input  logic [63:0]           icache_miss_addr_i,
    output logic                  refill_icache_valid_o,
    input  logic                  refill_icache_ready_i,
    output logic [LINE_SIZE-1:0]  refill_icache_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [63:0]           mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [BEAT_WIDTH-1:0] mem_resp_data_i,
    output logic                  busy_o
);
    localparam int ADDR_W = 64;
    localparam int CNT_W  = $clog2(BEAT_NUM);
    localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEAT_NUM - 1);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ~((ADDR_W'(1) << OFFSET_WIDTH) - ADDR_W'(1));

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_REFILL = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [LINE_SIZE-1:0] line;
    logic                 fifo_vld;
    logic [ADDR_W-1:0]    fifo_head;
    logic [ADDR_W-1:0]    push_addr;
    logic                 req_hs;

    assign push_addr = icache_miss_addr_i & OFFSET_MASK;
    assign req_hs    = (state == S_REQ) && mem_req_ready_i;

    fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (icache_miss_valid_i),
        .push_rdy (icache_miss_ready_o),
        .push_dat (push_addr),
        .pop_vld  (fifo_vld),
        .pop_rdy  (req_hs),
        .pop_dat  (fifo_head)
    );

    // The head only moves on the request handshake, so the address stays stable while waiting.
    assign mem_req_valid_o       = (state == S_REQ);
    assign mem_req_addr_o        = fifo_head;
    assign refill_icache_valid_o = (state == S_REFILL);
    assign refill_icache_data_o  = line;
    assign busy_o                = (state != S_IDLE) || fifo_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            line     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_vld) state <= S_REQ;
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        beat_cnt <= '0;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_resp_valid_i) begin
                        line[BEAT_WIDTH*beat_cnt +: BEAT_WIDTH] <= mem_resp_data_i;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= S_REFILL;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                S_REFILL: begin
                    // Go straight back to REQ when more misses are queued, avoiding an idle bubble.
                    if (refill_icache_ready_i) state <= fifo_vld ? S_REQ : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         icache_miss_valid_i = 1'b0;
    logic         icache_miss_ready_o;
    logic [63:0]  icache_miss_addr_i = '0;
    logic         refill_icache_valid_o;
    logic         refill_icache_ready_i = 1'b1;
    logic [511:0] refill_icache_data_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic [63:0]  mem_req_addr_o;
    logic         mem_resp_valid_i = 1'b0;
    logic [63:0]  mem_resp_data_i = '0;
    logic         busy_o;

    int checks = 0;
    int failures = 0;
    logic [63:0]  addr_q[$];
    logic [511:0] line_q[$];

    icache_refill_ctrl dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .icache_miss_valid_i   (icache_miss_valid_i),
        .icache_miss_ready_o   (icache_miss_ready_o),
        .icache_miss_addr_i    (icache_miss_addr_i),
        .refill_icache_valid_o (refill_icache_valid_o),
        .refill_icache_ready_i (refill_icache_ready_i),
        .refill_icache_data_o  (refill_icache_data_o),
        .mem_req_valid_o       (mem_req_valid_o),
        .mem_req_ready_i       (mem_req_ready_i),
        .mem_req_addr_o        (mem_req_addr_o),
        .mem_resp_valid_i      (mem_resp_valid_i),
        .mem_resp_data_i       (mem_resp_data_i),
        .busy_o                (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] seed);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[64*i +: 64] = seed + 64'(i);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_miss(input logic [63:0] line_addr, input logic [63:0] seed);
        addr_q.push_back(line_addr);
        line_q.push_back(mk_line(seed));
    endtask

    task automatic mem_accept(input bit stray);
        int n = 0;
        while (!mem_req_valid_o && n < 50) begin
            tick();
            n++;
        end
        if (!mem_req_valid_o) begin
            chk("mem_req_timeout", mem_req_valid_o, 1);
            return;
        end
        if (stray) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
            mem_resp_valid_i = 1'b0;
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
    endtask

    task automatic mem_beats(input logic [63:0] seed, input int gapmax, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(gapmax, 0)) tick();
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = seed + 64'(i);
            tick();
            mem_resp_valid_i = 1'b0;
        end
    endtask

    // Scoreboard monitor: compares every handshake against the queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
                if (addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mon_addr_unexpected: got %0h expected none", mem_req_addr_o);
                end else chk("mon_addr", mem_req_addr_o, addr_q.pop_front());
            end
            if (rst_n && refill_icache_valid_o && refill_icache_ready_i) begin
                if (line_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mon_line_unexpected: got %0h expected none", refill_icache_data_o);
                end else chk("mon_line", refill_icache_data_o, line_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_miss_ready", icache_miss_ready_o, 1);
        chk("rst_refill_valid", refill_icache_valid_o, 0);
        chk("rst_mem_req_valid", mem_req_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", refill_icache_data_o, 0);
        rst_n = 1'b1;
        tick();

        // Single miss with exact latency
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = 64'h0000_0000_8000_1234;
        expect_miss(64'h0000_0000_8000_1200, 64'h0);
        tick();
        icache_miss_valid_i = 1'b0;
        chk("single_req_T1", mem_req_valid_o, 0);
        chk("single_busy_T1", busy_o, 1);
        tick();
        chk("single_req_T2", mem_req_valid_o, 1);
        chk("single_addr_T2", mem_req_addr_o, 64'h0000_0000_8000_1200);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        mem_beats(64'h0, 0, 8);
        chk("single_refill_T11", refill_icache_valid_o, 1);
        tick();
        chk("single_refill_done", refill_icache_valid_o, 0);
        chk("single_busy_done", busy_o, 0);

        // Refill backpressure
        refill_icache_ready_i = 1'b0;
        icache_miss_valid_i   = 1'b1;
        icache_miss_addr_i    = 64'h0000_ABCD_0000_4467;
        expect_miss(64'h0000_ABCD_0000_4440, 64'h1111_0000_0000_0000);
        tick();
        icache_miss_valid_i = 1'b0;
        mem_accept(0);
        mem_beats(64'h1111_0000_0000_0000, 0, 8);
        repeat (5) begin
            chk("bp_valid", refill_icache_valid_o, 1);
            chk("bp_data", refill_icache_data_o, mk_line(64'h1111_0000_0000_0000));
            tick();
        end
        refill_icache_ready_i = 1'b1;
        tick();
        chk("bp_valid_after", refill_icache_valid_o, 0);
        chk("bp_busy_after", busy_o, 0);

        // FIFO full, in-order return, back-to-back service
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = 64'h1000;
        expect_miss(64'h1000, 64'hA000_0000_0000_0000);
        tick();
        icache_miss_addr_i  = 64'h2040;
        expect_miss(64'h2040, 64'hB000_0000_0000_0000);
        tick();
        chk("full_rdy", icache_miss_ready_o, 0);
        icache_miss_addr_i  = 64'h3080;
        expect_miss(64'h3080, 64'hC000_0000_0000_0000);
        repeat (3) begin
            tick();
            chk("full_rdy_held", icache_miss_ready_o, 0);
        end
        chk("full_req_addr", mem_req_addr_o, 64'h1000);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        chk("full_rdy_after_pop", icache_miss_ready_o, 1);
        tick();
        icache_miss_valid_i = 1'b0;
        chk("full_third_pushed", icache_miss_ready_o, 0);
        mem_beats(64'hA000_0000_0000_0000, 0, 8);
        tick();
        chk("b2b_req", mem_req_valid_o, 1);
        mem_accept(0);
        mem_beats(64'hB000_0000_0000_0000, 1, 8);
        mem_accept(0);
        mem_beats(64'hC000_0000_0000_0000, 0, 8);
        tick();
        chk("b2b_busy_done", busy_o, 0);

        // Stray beat while idle leaves the buffer alone
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 64'h5A5A_5A5A_5A5A_5A5A;
        tick();
        mem_resp_valid_i = 1'b0;
        chk("stray_idle_data", refill_icache_data_o, mk_line(64'hC000_0000_0000_0000));

        // Gapped beats plus stray pulse during REQ
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = 64'h5555_0000_0000_00C5;
        expect_miss(64'h5555_0000_0000_00C0, 64'h0123_4567_89AB_CDE0);
        tick();
        icache_miss_valid_i = 1'b0;
        mem_accept(1);
        mem_beats(64'h0123_4567_89AB_CDE0, 3, 8);
        tick();
        chk("gap_busy_done", busy_o, 0);

        // Reset during RESP
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = 64'h9000_0000_0000_1000;
        addr_q.push_back(64'h9000_0000_0000_1000);
        tick();
        icache_miss_addr_i  = 64'h7000;
        tick();
        icache_miss_valid_i = 1'b0;
        mem_accept(0);
        mem_beats(64'hEEEE_0000_0000_0000, 0, 4);
        rst_n = 1'b0;
        #1;
        chk("mrst_mem_req", mem_req_valid_o, 0);
        chk("mrst_refill", refill_icache_valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_miss_ready", icache_miss_ready_o, 1);
        chk("mrst_data", refill_icache_data_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
        chk("mrst_fifo_empty", mem_req_valid_o, 0);
        chk("mrst_busy_after", busy_o, 0);
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = 64'h9000_0000_0000_2077;
        expect_miss(64'h9000_0000_0000_2040, 64'h7777_0000_0000_0010);
        tick();
        icache_miss_valid_i = 1'b0;
        mem_accept(0);
        mem_beats(64'h7777_0000_0000_0010, 0, 8);
        tick();
        chk("mrst_fresh_done", busy_o, 0);

        repeat (3) tick();
        chk("addr_q_drained", 512'(addr_q.size()), 0);
        chk("line_q_drained", 512'(line_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
